// File: rtl/adc_scan_controller.sv
// Multi-channel SAR ADC scan sequencer: mux settle, sample, MSB-first
// successive approximation, optional power-of-two averaging, ready/valid result.
module adc_scan_controller #(
    parameter int unsigned WIDTH    = 12,
    parameter int unsigned NCH      = 4,
    parameter int unsigned SETTLE   = 2,
    parameter int unsigned AVG_LOG2 = 0,
    localparam int unsigned CHW     = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_,
    input  logic             cont,
    input  logic [NCH-1:0]   ch_mask,
    input  logic             comparator,
    output logic [CHW-1:0]   ch_sel,
    output logic             sample_and_hold,
    output logic             pwr_gate,
    output logic             dac_rst,
    output logic [WIDTH-1:0] dac,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CHW-1:0]   res_ch,
    output logic [WIDTH-1:0] res_data,
    output logic             scan_done
);

    localparam int unsigned ACC_W = WIDTH + AVG_LOG2;
    localparam int unsigned CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned SET_W = $clog2(SETTLE + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);
    localparam logic [WIDTH-1:0] BIT_MSB  = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SELECT  = 3'd1;
    localparam logic [2:0] S_SAMPLE  = 3'd2;
    localparam logic [2:0] S_CONVERT = 3'd3;
    localparam logic [2:0] S_ACCUM   = 3'd4;
    localparam logic [2:0] S_OUT     = 3'd5;

    logic [2:0]       state_q,    state_d;
    logic             en_q;
    logic [NCH-1:0]   cand_q;
    logic [NCH-1:0]   mask_q,     mask_d;
    logic             armed_q,    armed_d;
    logic [CHW-1:0]   ch_q,       ch_d;
    logic [SET_W-1:0] settle_q,   settle_d;
    logic [WIDTH-1:0] sar_q,      sar_d;
    logic [WIDTH-1:0] bit_q,      bit_d;
    logic [ACC_W-1:0] acc_q,      acc_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             rvalid_q,   rvalid_d;
    logic [CHW-1:0]   rch_q,      rch_d;
    logic [WIDTH-1:0] rdata_q,    rdata_d;
    logic             done_q,     done_d;

    logic             nxt_found;
    logic [CHW-1:0]   nxt_ch;

    function automatic logic [CHW-1:0] lowest_set(input logic [NCH-1:0] m);
        lowest_set = '0;
        for (int unsigned i = NCH; i > 0; i--) begin
            if (m[i-1]) lowest_set = CHW'(i - 1);
        end
    endfunction

    // Next enabled channel strictly above the current one, lowest first.
    always_comb begin
        nxt_found = 1'b0;
        nxt_ch    = '0;
        for (int unsigned i = NCH; i > 0; i--) begin
            if (mask_q[i-1] && (CHW'(i - 1) > ch_q)) begin
                nxt_found = 1'b1;
                nxt_ch    = CHW'(i - 1);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        armed_d  = armed_q;
        ch_d     = ch_q;
        settle_d = settle_q;
        sar_d    = sar_q;
        bit_d    = bit_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        rvalid_d = rvalid_q;
        rch_d    = rch_q;
        rdata_d  = rdata_q;
        done_d   = 1'b0;

        if (rvalid_q && res_ready) rvalid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (en_) armed_d = 1'b1;
                // en_ and ch_mask are taken from their registered copies so both align.
                if (!en_q && !en_ && armed_q && (cand_q != '0)) begin
                    mask_d   = cand_q;
                    ch_d     = lowest_set(cand_q);
                    acc_d    = '0;
                    cnt_d    = '0;
                    settle_d = '0;
                    state_d  = S_SELECT;
                end
            end
            S_SELECT: begin
                if (en_) begin
                    state_d = S_IDLE;
                end else if (settle_q == SET_LAST) begin
                    state_d = S_SAMPLE;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            S_SAMPLE: begin
                if (en_) begin
                    state_d = S_IDLE;
                end else begin
                    sar_d   = '0;
                    bit_d   = BIT_MSB;
                    state_d = S_CONVERT;
                end
            end
            S_CONVERT: begin
                if (en_) begin
                    state_d = S_IDLE;
                end else begin
                    if (comparator) sar_d = sar_q | bit_q;
                    bit_d = bit_q >> 1;
                    if (bit_q[0]) state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (en_) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = acc_q + ACC_W'(sar_q);
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_OUT;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = S_SAMPLE;
                    end
                end
            end
            S_OUT: begin
                if (!rvalid_q || res_ready) begin
                    rvalid_d = 1'b1;
                    rch_d    = ch_q;
                    rdata_d  = WIDTH'(acc_q >> AVG_LOG2);
                    acc_d    = '0;
                    cnt_d    = '0;
                    settle_d = '0;
                    if (nxt_found) begin
                        ch_d    = nxt_ch;
                        state_d = S_SELECT;
                    end else begin
                        done_d = 1'b1;
                        if (cont && !en_) begin
                            ch_d    = lowest_set(mask_q);
                            state_d = S_SELECT;
                        end else begin
                            state_d = S_IDLE;
                            if (!cont) armed_d = 1'b0;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            en_q     <= 1'b1;
            cand_q   <= '0;
            mask_q   <= '0;
            armed_q  <= 1'b1;
            ch_q     <= '0;
            settle_q <= '0;
            sar_q    <= '0;
            bit_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            rch_q    <= '0;
            rdata_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_;
            cand_q   <= ch_mask;
            mask_q   <= mask_d;
            armed_q  <= armed_d;
            ch_q     <= ch_d;
            settle_q <= settle_d;
            sar_q    <= sar_d;
            bit_q    <= bit_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            rch_q    <= rch_d;
            rdata_q  <= rdata_d;
            done_q   <= done_d;
        end
    end

    assign ch_sel          = ch_q;
    assign sample_and_hold = (state_q == S_SAMPLE);
    assign dac_rst         = (state_q == S_SAMPLE);
    assign pwr_gate        = (state_q == S_SAMPLE) || (state_q == S_CONVERT);
    assign busy            = (state_q != S_IDLE);
    assign dac             = (state_q == S_CONVERT) ? (sar_q | bit_q) : sar_q;
    assign res_valid       = rvalid_q;
    assign res_ch          = rch_q;
    assign res_data        = rdata_q;
    assign scan_done       = done_q;

endmodule

// File: tb/tb_adc_scan_controller.sv
// Randomized bench for adc_scan_controller: comparator models an ideal input
// code per channel; expected results come from mask order and plain averaging.
module tb_adc_scan_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        en_n, cont, comparator, res_ready;
    logic [3:0]  ch_mask;
    logic [1:0]  ch_sel, res_ch;
    logic        sah, pwr, dac_rst, busy, res_valid, scan_done;
    logic [11:0] dac, res_data;

    logic        a_en_n, a_cont, a_comp, a_res_ready;
    logic [3:0]  a_ch_mask;
    logic [1:0]  a_ch_sel, a_res_ch;
    logic        a_sah, a_pwr, a_dac_rst, a_busy, a_res_valid, a_scan_done;
    logic [11:0] a_dac, a_res_data;

    logic [11:0] code_tab  [4];
    logic [11:0] avg_codes [4];
    logic [1:0]  a_pass;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [1:0]  ch;
        logic [11:0] data;
    } exp_t;

    always #5 clk = ~clk;

    adc_scan_controller dut (
        .clk(clk), .reset(reset), .en_(en_n), .cont(cont), .ch_mask(ch_mask),
        .comparator(comparator), .ch_sel(ch_sel), .sample_and_hold(sah),
        .pwr_gate(pwr), .dac_rst(dac_rst), .dac(dac), .busy(busy),
        .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch),
        .res_data(res_data), .scan_done(scan_done)
    );

    adc_scan_controller #(.AVG_LOG2(2)) dut_avg (
        .clk(clk), .reset(reset), .en_(a_en_n), .cont(a_cont), .ch_mask(a_ch_mask),
        .comparator(a_comp), .ch_sel(a_ch_sel), .sample_and_hold(a_sah),
        .pwr_gate(a_pwr), .dac_rst(a_dac_rst), .dac(a_dac), .busy(a_busy),
        .res_valid(a_res_valid), .res_ready(a_res_ready), .res_ch(a_res_ch),
        .res_data(a_res_data), .scan_done(a_scan_done)
    );

    // Ideal comparator: trial value not above the analog input keeps the bit.
    assign comparator = (dac <= code_tab[ch_sel]);

    always @(posedge clk or posedge reset) begin
        if (reset) a_pass <= 2'd0;
        else if (a_sah) a_pass <= a_pass + 2'd1;
    end
    assign a_comp = (a_dac <= avg_codes[a_pass - 2'd1]);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rise(output int cyc);
        logic prev;
        prev = res_valid;
        cyc  = -1;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (res_valid && !prev) begin
                cyc = i;
                break;
            end
            prev = res_valid;
        end
    endtask

    task automatic rearm();
        @(negedge clk);
        en_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ctl"}, {22'd0, ch_sel, sah, pwr, dac_rst, busy, res_valid, res_ch, scan_done}, 32'd0);
        check_eq({tag, "_dac"}, {20'd0, dac}, 32'd0);
        check_eq({tag, "_data"}, {20'd0, res_data}, 32'd0);
    endtask

    task automatic run_scan(input logic [3:0] m);
        exp_t q[$];
        exp_t e;
        int   c, n;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                e.ch   = 2'(i);
                e.data = code_tab[i];
                q.push_back(e);
            end
        end
        n = q.size();
        @(negedge clk);
        ch_mask = m;
        en_n    = 1'b0;
        tick();
        for (int k = 0; k < n; k++) begin
            e = q.pop_front();
            wait_rise(c);
            check_eq("latency", c, (k == 0) ? 18 : 17);
            check_eq("res_ch", {30'd0, res_ch}, {30'd0, e.ch});
            check_eq("res_data", {20'd0, res_data}, {20'd0, e.data});
            check_eq("scan_done", {31'd0, scan_done}, (k == n - 1) ? 32'd1 : 32'd0);
            if (k == n - 1) check_eq("busy_end", {31'd0, busy}, 32'd0);
        end
        repeat (5) tick();
        check_eq("disarm_idle", {31'd0, busy}, 32'd0);
        rearm();
    endtask

    task automatic run_avg();
        int c, samples, sum;
        sum = 0;
        for (int i = 0; i < 4; i++) sum += int'(avg_codes[i]);
        @(negedge clk);
        a_ch_mask = 4'b0010;
        a_en_n    = 1'b0;
        tick();
        c       = -1;
        samples = 0;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (a_sah) samples++;
            if (a_res_valid) begin
                c = i;
                break;
            end
        end
        check_eq("avg_latency", c, 60);
        check_eq("avg_samples", samples, 4);
        check_eq("avg_ch", {30'd0, a_res_ch}, 32'd1);
        check_eq("avg_data", {20'd0, a_res_data}, 32'(sum >> 2));
        check_eq("avg_done", {31'd0, a_scan_done}, 32'd1);
        @(negedge clk);
        a_en_n = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        int          c, rv_seen, done_seen, busy_seen;
        logic [3:0]  m;

        reset = 1'b0; en_n = 1'b1; cont = 1'b0; ch_mask = '0; res_ready = 1'b1;
        a_en_n = 1'b1; a_cont = 1'b0; a_ch_mask = '0; a_res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            code_tab[i]  = '0;
            avg_codes[i] = '0;
        end
        #2 reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        repeat (2) tick();

        // Reference scan: channels 0 and 2
        code_tab[0] = 12'hA5C; code_tab[1] = 12'h111;
        code_tab[2] = 12'h3FF; code_tab[3] = 12'h222;
        run_scan(4'b0101);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 4; i++) code_tab[i] = 12'($urandom);
            m = 4'($urandom_range(1, 15));
            run_scan(m);
        end

        // Backpressure: second result stalls in OUT until the first is taken
        code_tab[0] = 12'hA5C; code_tab[2] = 12'h3FF;
        @(negedge clk);
        res_ready = 1'b0; ch_mask = 4'b0101; en_n = 1'b0;
        tick();
        wait_rise(c);
        check_eq("stall_first_lat", c, 18);
        check_eq("stall_first_ch", {30'd0, res_ch}, 32'd0);
        repeat (25) tick();
        check_eq("stall_valid", {31'd0, res_valid}, 32'd1);
        check_eq("stall_hold_data", {20'd0, res_data}, 32'h0A5C);
        check_eq("stall_ch_sel", {30'd0, ch_sel}, 32'd2);
        check_eq("stall_pwr", {31'd0, pwr}, 32'd0);
        check_eq("stall_busy", {31'd0, busy}, 32'd1);
        check_eq("stall_dac", {20'd0, dac}, 32'h03FF);
        repeat (3) tick();
        check_eq("stall_dac_const", {20'd0, dac}, 32'h03FF);
        @(negedge clk);
        res_ready = 1'b1;
        tick();
        check_eq("swap_valid", {31'd0, res_valid}, 32'd1);
        check_eq("swap_ch", {30'd0, res_ch}, 32'd2);
        check_eq("swap_data", {20'd0, res_data}, 32'h03FF);
        check_eq("swap_done", {31'd0, scan_done}, 32'd1);
        tick();
        check_eq("accept_clears", {31'd0, res_valid}, 32'd0);
        rearm();

        // Abort during CONVERT at bit 5
        code_tab[1] = 12'($urandom);
        @(negedge clk);
        ch_mask = 4'b0010; en_n = 1'b0;
        tick();
        for (int i = 0; i < 50; i++) begin
            tick();
            if (pwr && !sah) break;
        end
        repeat (6) tick();
        check_eq("abort_bit5", {20'd0, dac & 12'h03F}, 32'h020);
        en_n = 1'b1;
        tick();
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        check_eq("abort_pwr", {31'd0, pwr}, 32'd0);
        rv_seen = 0; done_seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (res_valid) rv_seen++;
            if (scan_done) done_seen++;
        end
        check_eq("abort_no_valid", rv_seen, 0);
        check_eq("abort_no_done", done_seen, 0);

        // Asynchronous reset mid-CONVERT with a pending result
        code_tab[2] = 12'($urandom_range(1, 4095));
        @(negedge clk);
        res_ready = 1'b0; cont = 1'b1; ch_mask = 4'b0100; en_n = 1'b0;
        tick();
        repeat (25) tick();
        check_eq("pre_rst_pwr", {31'd0, pwr}, 32'd1);
        check_eq("pre_rst_valid", {31'd0, res_valid}, 32'd1);
        #3 reset = 1'b1;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        cont = 1'b0; en_n = 1'b1; res_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) tick();

        // Continuous scanning of a single channel
        code_tab[3] = 12'($urandom);
        @(negedge clk);
        cont = 1'b1; ch_mask = 4'b1000; en_n = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            wait_rise(c);
            check_eq("cont_latency", c, (k == 0) ? 18 : 17);
            check_eq("cont_ch", {30'd0, res_ch}, 32'd3);
            check_eq("cont_data", {20'd0, res_data}, {20'd0, code_tab[3]});
            check_eq("cont_done", {31'd0, scan_done}, 32'd1);
        end
        @(negedge clk);
        en_n = 1'b1;
        repeat (30) tick();
        check_eq("cont_stop_idle", {31'd0, busy}, 32'd0);
        @(negedge clk);
        cont = 1'b0; ch_mask = 4'b0000; en_n = 1'b0;
        busy_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busy) busy_seen++;
        end
        check_eq("empty_mask_idle", busy_seen, 0);
        rearm();

        // Averaging instance: reference codes, then random codes
        avg_codes[0] = 12'd100; avg_codes[1] = 12'd101;
        avg_codes[2] = 12'd102; avg_codes[3] = 12'd104;
        run_avg();
        for (int i = 0; i < 4; i++) avg_codes[i] = 12'($urandom);
        run_avg();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_scan_controller.md
ADC_SCAN_CONTROLLER -- requirements
Module: adc_scan_controller

Interface
REQ-001 SHALL have parameter WIDTH, default 12, meaning SAR resolution in bits (>=2).
REQ-002 SHALL have parameter NCH, default 4, meaning number of analog mux channels (>=2); CHW = clog2(NCH).
REQ-003 SHALL have parameter SETTLE, default 2, meaning mux settling cycles per channel (>=1).
REQ-004 SHALL have parameter AVG_LOG2, default 0, meaning log2 of conversions averaged per result (0..4).
REQ-005 SHALL have ports:
- clk  in  1  system clock; the only clock
- reset  in  1  asynchronous, active-high reset
- en_  in  1  active-low run/enable
- cont  in  1  1 = continuous scanning, 0 = single scan
- ch_mask  in  NCH  channel enable mask, latched at scan start
- comparator  in  1  external comparator result
- ch_sel  out  CHW  analog mux select
- sample_and_hold  out  1  S&H control
- pwr_gate  out  1  DAC/comparator power enable
- dac_rst  out  1  capacitive DAC reset
- dac  out  WIDTH  DAC drive value
- busy  out  1  high when not IDLE
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_ch  out  CHW  channel of res_data
- res_data  out  WIDTH  averaged conversion result
- scan_done  out  1  one-cycle pulse, last channel of scan delivered

Function
REQ-006 SHALL implement states IDLE, SELECT, SAMPLE, CONVERT, ACCUM, OUT.
REQ-007 IDLE: if en_=0, start armed, and latched-candidate ch_mask!=0 -> latch ch_mask, ch_sel = lowest set bit, clear accumulator and sample count, go SELECT; ch_mask=0 -> stay IDLE.
REQ-008 SELECT SHALL last exactly SETTLE cycles, then SAMPLE.
REQ-009 SAMPLE SHALL last 1 cycle: sample_and_hold=1, dac_rst=1, SAR result cleared, bit mask = MSB; then CONVERT.
REQ-010 CONVERT SHALL last exactly WIDTH cycles: dac = result|mask; comparator=1 keeps the bit; mask shifts right each cycle; MSB first.
REQ-011 ACCUM SHALL last 1 cycle: accumulator (WIDTH+AVG_LOG2 bits, no overflow possible) += SAR result; if sample count < 2^AVG_LOG2-1 then increment count, go SAMPLE (no re-settle), else go OUT.
REQ-012 Outside CONVERT, dac SHALL equal the held SAR result.
REQ-013 pwr_gate SHALL be 1 in SAMPLE and CONVERT only; busy SHALL be 1 in all states except IDLE.
REQ-014 OUT: when res_valid=0 or res_ready=1 -> load res_data = accumulator >> AVG_LOG2 (truncating), res_ch = ch_sel, res_valid=1, then advance; otherwise stall in OUT holding all state.
REQ-015 Advance: next higher set bit of latched mask -> ch_sel updates, clear accumulator/count, SELECT; no higher bit -> scan_done=1 for that cycle, then cont=1 and en_=0 -> restart at lowest set bit (SELECT), else IDLE.
REQ-016 res_valid SHALL fall on a cycle where res_valid=1 and res_ready=1 with no new load; simultaneous accept and load keeps res_valid=1 with new data.
REQ-017 With cont=0, start SHALL be disarmed when a scan completes and re-armed only after en_ is sampled 1 in IDLE.
REQ-018 en_=1 sampled in SELECT, SAMPLE, CONVERT or ACCUM SHALL abort to IDLE next cycle; partial result discarded; no res_valid load, no scan_done.
REQ-019 Abort or state changes SHALL never clear a pending res_valid/res_data; only acceptance or reset clears it.
REQ-020 ch_mask changes mid-scan SHALL have no effect until the next scan start.
REQ-021 Latency, AVG_LOG2=0: res_valid rises SETTLE+WIDTH+4 cycles after the edge sampling en_=0 in IDLE; next channel result SETTLE+WIDTH+3 cycles later when unstalled.

Reset
REQ-022 reset=1 SHALL asynchronously force IDLE, start armed, and all outputs, accumulator, SAR and mask registers to 0, including mid-conversion.

Verification
REQ-023 Defaults, mask=4'b0101, cont=0, res_ready=1, comparator models ch0=0xA5C, ch2=0x3FF; en_ low -> (ch0,0xA5C) valid 18 cycles later, (ch2,0x3FF) 17 cycles after that with scan_done, then IDLE, busy=0.
REQ-024 Same, res_ready=0 -> ch2 stalls in OUT, ch_sel=2, dac constant, pwr_gate=0; raise res_ready -> ch0 accepted, ch2 loaded same edge, res_valid stays 1.
REQ-025 AVG_LOG2=2, single channel, codes 100,101,102,104 -> four SAMPLE/CONVERT passes, one SELECT, res_data=101.
REQ-026 en_ raised during CONVERT bit 5 -> IDLE next cycle, pwr_gate=0, no res_valid, no scan_done.
REQ-027 reset asserted mid-CONVERT -> all outputs 0 immediately, before next clk edge.
REQ-028 cont=1, mask=4'b1000 -> repeated ch3 results each 17 cycles with scan_done each; ch_mask=0 with en_=0 -> busy stays 0.
